// File: rtl/stream_framer_pkg.sv
// stream_framer_pkg: shared FSM encoding and ceil-log2 helper for the stream framer.
package stream_framer_pkg;

   typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_e;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) if ((1 << i) < v) r = i + 1;
      return r;
   endfunction

endpackage

// File: rtl/stream_framer_raster_counter.sv
// raster_counter: (vcnt, hcnt) raster walk with row/frame wrap and a last-position flag.
module raster_counter
   import stream_framer_pkg::*;
#(
   parameter  int HEIGHT = 4,
   parameter  int WIDTH  = 6,
   localparam int V_BITW = clog2(HEIGHT),
   localparam int H_BITW = clog2(WIDTH)
) (
   input  logic              clock,
   input  logic              n_rst,
   input  logic              clear,
   input  logic              step,
   output logic [V_BITW-1:0] vcnt,
   output logic [H_BITW-1:0] hcnt,
   output logic              last
);

   logic [V_BITW-1:0] vcnt_q, vcnt_d;
   logic [H_BITW-1:0] hcnt_q, hcnt_d;
   logic              h_end, v_end;

   assign h_end = hcnt_q == H_BITW'(WIDTH - 1);
   assign v_end = vcnt_q == V_BITW'(HEIGHT - 1);

   // clear wins over step so a restarted frame always begins at (0,0)
   always_comb begin
      vcnt_d = vcnt_q;
      hcnt_d = hcnt_q;
      if (clear) begin
         vcnt_d = '0;
         hcnt_d = '0;
      end else if (step) begin
         hcnt_d = h_end ? '0 : hcnt_q + H_BITW'(1);
         if (h_end) vcnt_d = v_end ? '0 : vcnt_q + V_BITW'(1);
      end
   end

   always_ff @(posedge clock) begin
      if (!n_rst) begin
         vcnt_q <= '0;
         hcnt_q <= '0;
      end else begin
         vcnt_q <= vcnt_d;
         hcnt_q <= hcnt_d;
      end
   end

   assign vcnt = vcnt_q;
   assign hcnt = hcnt_q;
   assign last = h_end && v_end;

endmodule

// File: rtl/stream_framer.sv
// stream_framer: turns a valid/ready pixel stream with SOF into a registered raster
// stream (pixel, vcnt, hcnt, enable), walking blanking at one position per cycle.
module stream_framer
   import stream_framer_pkg::*;
#(
   parameter  int BIT_WIDTH    = 8,
   parameter  int IMAGE_HEIGHT = 3,
   parameter  int IMAGE_WIDTH  = 4,
   parameter  int FRAME_HEIGHT = 4,
   parameter  int FRAME_WIDTH  = 6,
   localparam int V_BITW       = clog2(FRAME_HEIGHT),
   localparam int H_BITW       = clog2(FRAME_WIDTH)
) (
   input  logic                 clock,
   input  logic                 n_rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [BIT_WIDTH-1:0] in_pixel,
   input  logic                 in_sof,
   input  logic                 hold,
   output logic                 out_enable,
   output logic [BIT_WIDTH-1:0] out_pixel,
   output logic [V_BITW-1:0]    out_vcnt,
   output logic [H_BITW-1:0]    out_hcnt,
   output logic                 frame_done,
   output logic                 sof_err
);

   state_e                state_q, state_d;
   logic                  sof_err_q, sof_err_d;
   logic                  out_enable_q, frame_done_q;
   logic [BIT_WIDTH-1:0]  out_pixel_q;
   logic [V_BITW-1:0]     out_vcnt_q, vcnt;
   logic [H_BITW-1:0]     out_hcnt_q, hcnt;
   logic                  last, in_img, early_sof, ready_c, advance, clear;

   raster_counter #(.HEIGHT(FRAME_HEIGHT), .WIDTH(FRAME_WIDTH)) u_cnt (
      .clock (clock),
      .n_rst (n_rst),
      .clear (clear),
      .step  (advance),
      .vcnt  (vcnt),
      .hcnt  (hcnt),
      .last  (last)
   );

   assign in_img    = vcnt < V_BITW'(IMAGE_HEIGHT) && hcnt < H_BITW'(IMAGE_WIDTH);
   assign early_sof = in_sof && in_valid && (vcnt != '0 || hcnt != '0);

   // early SOF is only recognised at image positions; a next-frame SOF waiting
   // through trailing blanking is the normal back-to-back case
   always_comb begin
      state_d   = state_q;
      sof_err_d = sof_err_q;
      ready_c   = 1'b0;
      advance   = 1'b0;
      clear     = 1'b0;
      if (state_q == ST_IDLE) begin
         ready_c = !in_sof;
         if (in_valid && in_sof) state_d = ST_RUN;
      end else if (!hold) begin
         if (!in_img) begin
            advance = 1'b1;
         end else if (early_sof) begin
            clear     = 1'b1;
            sof_err_d = 1'b1;
         end else begin
            ready_c = 1'b1;
            advance = in_valid;
         end
         if (advance && last) state_d = ST_IDLE;
      end
   end

   always_ff @(posedge clock) begin
      if (!n_rst) begin
         state_q      <= ST_IDLE;
         sof_err_q    <= 1'b0;
         out_enable_q <= 1'b0;
         frame_done_q <= 1'b0;
         out_pixel_q  <= '0;
         out_vcnt_q   <= '0;
         out_hcnt_q   <= '0;
      end else begin
         state_q      <= state_d;
         sof_err_q    <= sof_err_d;
         out_enable_q <= advance;
         frame_done_q <= advance && last;
         if (advance) begin
            out_pixel_q <= in_img ? in_pixel : '0;
            out_vcnt_q  <= vcnt;
            out_hcnt_q  <= hcnt;
         end
      end
   end

   assign in_ready   = ready_c && n_rst;
   assign out_enable = out_enable_q;
   assign out_pixel  = out_pixel_q;
   assign out_vcnt   = out_vcnt_q;
   assign out_hcnt   = out_hcnt_q;
   assign frame_done = frame_done_q;
   assign sof_err    = sof_err_q;

endmodule

// File: tb/tb_stream_framer.sv
// tb_stream_framer: linear-position frame model checked every cycle, directed scenarios
// pinned by literal expectations, then randomized traffic.
module tb_stream_framer;

   localparam int BW = 8, IH = 3, IW = 4, FH = 4, FW = 6, N = FH * FW;

   logic          clock = 1'b0, n_rst = 1'b0, in_valid = 1'b0, in_sof = 1'b0, hold = 1'b0;
   logic [BW-1:0] in_pixel = '0;
   logic          in_ready, out_enable, frame_done, sof_err;
   logic [BW-1:0] out_pixel;
   logic [1:0]    out_vcnt;
   logic [2:0]    out_hcnt;

   stream_framer #(
      .BIT_WIDTH(BW), .IMAGE_HEIGHT(IH), .IMAGE_WIDTH(IW),
      .FRAME_HEIGHT(FH), .FRAME_WIDTH(FW)
   ) dut (
      .clock(clock), .n_rst(n_rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_pixel(in_pixel), .in_sof(in_sof), .hold(hold), .out_enable(out_enable),
      .out_pixel(out_pixel), .out_vcnt(out_vcnt), .out_hcnt(out_hcnt),
      .frame_done(frame_done), .sof_err(sof_err)
   );

   always #5 clock = ~clock;

   int total = 0, bad = 0;
   bit m_run, m_err, m_en, m_done, xfer;
   int m_p, m_pix, m_v, m_h, pix, en_cnt, dv, dh, hc;
   int rec [FH][8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // the frame is a linear sequence of N positions; row/column come from div/mod
   task automatic tick();
      bit img, rdy, adv, early, go;
      int v, h;
      #1;
      v = m_p / FW;
      h = m_p % FW;
      img = v < IH && h < IW;
      rdy = 0; adv = 0; early = 0; go = 0;
      if (n_rst) begin
         if (!m_run) begin
            rdy = !in_sof;
            go  = in_valid && in_sof;
         end else if (!hold) begin
            if (!img) adv = 1;
            else if (in_valid && in_sof && m_p != 0) early = 1;
            else begin
               rdy = 1;
               adv = in_valid;
            end
         end
      end
      chk("ready", in_ready, rdy);
      xfer = rdy && in_valid;
      @(posedge clock);
      #1;
      if (!n_rst) begin
         m_run = 0; m_p = 0; m_err = 0; m_en = 0; m_done = 0; m_pix = 0; m_v = 0; m_h = 0;
      end else begin
         m_en   = adv;
         m_done = adv && m_p == N - 1;
         if (adv) begin
            m_pix = img ? int'(in_pixel) : 0;
            m_v   = v;
            m_h   = h;
            m_p   = (m_p + 1) % N;
            if (m_p == 0) m_run = 0;
         end
         if (early) begin
            m_p   = 0;
            m_err = 1;
         end
         if (go) m_run = 1;
      end
      chk("enable", out_enable, m_en);
      chk("frame_done", frame_done, m_done);
      chk("pixel", out_pixel, m_pix);
      chk("vcnt", out_vcnt, m_v);
      chk("hcnt", out_hcnt, m_h);
      chk("sof_err", sof_err, m_err);
      if (out_enable) begin
         rec[out_vcnt][out_hcnt] = int'(out_pixel);
         en_cnt++;
      end
      if (frame_done) begin
         dv = int'(out_vcnt);
         dh = int'(out_hcnt);
      end
   endtask

   task automatic feed(input int n, input int last_pix);
      for (int c = 0; c < n; c++) begin
         in_valid = pix <= last_pix;
         in_sof   = pix == 1;
         in_pixel = BW'(pix);
         tick();
         if (xfer) pix++;
      end
   endtask

   task automatic feed_until(input int target, input int budget);
      for (int c = 0; c < budget && !(m_run && m_p == target); c++) begin
         in_valid = 1;
         in_sof   = pix == 1;
         in_pixel = BW'(pix);
         tick();
         if (xfer) pix++;
      end
      chk("reach_pos", m_p, target);
   endtask

   task automatic clear_rec();
      for (int v = 0; v < FH; v++) for (int h = 0; h < 8; h++) rec[v][h] = -1;
      en_cnt = 0; dv = -1; dh = -1;
   endtask

   initial begin
      n_rst = 0;
      tick();
      tick();
      chk("rst_ready", in_ready, 0);
      chk("rst_enable", out_enable, 0);
      chk("rst_pixel", out_pixel, 0);
      n_rst = 1;

      clear_rec();
      pix = 1;
      feed(30, 12);
      chk("f1_count", en_cnt, 24);
      chk("f1_p00", rec[0][0], 1);
      chk("f1_p03", rec[0][3], 4);
      chk("f1_p10", rec[1][0], 5);
      chk("f1_p23", rec[2][3], 12);
      chk("f1_blank14", rec[1][4], 0);
      chk("f1_blank32", rec[3][2], 0);
      chk("f1_done_v", dv, 3);
      chk("f1_done_h", dh, 5);

      clear_rec();
      in_sof = 0;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1;
         in_pixel = BW'(100 + i);
         tick();
         chk("idle_ready", in_ready, 1);
         chk("idle_enable", out_enable, 0);
      end
      pix = 50;
      for (int c = 0; c < 60; c++) begin
         in_valid = (c % 2 == 0) && pix <= 61;
         in_sof   = pix == 50;
         in_pixel = BW'(pix);
         tick();
         if (xfer) pix++;
      end
      chk("tog_p00", rec[0][0], 50);
      chk("tog_p23", rec[2][3], 61);
      chk("tog_count", en_cnt, 24);

      clear_rec();
      pix = 1;
      feed_until(FW + 2, 30);
      hold = 1;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("hold_enable", out_enable, 0);
         chk("hold_ready", in_ready, 0);
      end
      hold = 0;
      feed(40, 12);
      chk("hold_p11", rec[1][1], 6);
      chk("hold_p12", rec[1][2], 7);
      chk("hold_count", en_cnt, 24);

      clear_rec();
      pix = 1;
      feed_until(2 * FW + 1, 40);
      in_valid = 1;
      in_sof   = 1;
      in_pixel = 8'd77;
      tick();
      chk("esof_err", sof_err, 1);
      chk("esof_enable", out_enable, 0);
      tick();
      chk("esof_en2", out_enable, 1);
      chk("esof_v", out_vcnt, 0);
      chk("esof_h", out_hcnt, 0);
      chk("esof_pix", out_pixel, 77);
      pix = 78;
      feed(40, 88);
      chk("esof_p23", rec[2][3], 88);
      chk("esof_sticky", sof_err, 1);

      pix = 1;
      feed_until(FW + 3, 30);
      n_rst = 0;
      tick();
      chk("mrst_ready", in_ready, 0);
      chk("mrst_enable", out_enable, 0);
      chk("mrst_pixel", out_pixel, 0);
      chk("mrst_v", out_vcnt, 0);
      chk("mrst_h", out_hcnt, 0);
      chk("mrst_err", sof_err, 0);
      n_rst = 1;
      en_cnt = 0;
      pix = 2;
      feed(6, 100);
      chk("mrst_idle", en_cnt, 0);

      for (int c = 0; c < 4000; c++) begin
         n_rst    = ($urandom % 400) != 0;
         in_valid = ($urandom % 4) != 0;
         in_sof   = ($urandom % 16) == 0;
         hold     = ($urandom % 8) == 0;
         in_pixel = BW'($urandom);
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
